fm_eg_seq: RTL

Parametrised, self-sequencing FM envelope generator for the aq32 audio subsystem. On each sample strobe it walks all operator slots, one slot per clock. Per-slot ADSR state (stage, rate counter, envelope, previous key-on) is held internally. For each slot it emits a registered attenuation value to the operator pipeline. Over the previous single-slot EG it adds configurable slot count and widths, edge-triggered key-on retrigger from any stage, instant attack at rate 15, a power-up state-clear sweep and overrun detection.

---
 rtl/fm_eg_seq.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fm_eg_seq.sv
// fm_eg_seq: self-sequencing FM envelope generator.
// A sample strobe sweeps all operator slots, one slot per clock. Each slot keeps
// its own ADSR stage, rate counter, envelope and previous key-on bit. The bench
// presents the slot parameters for op_sel in the same cycle. A registered
// attenuation is emitted one cycle later.
module fm_eg_seq #(
    parameter int unsigned NUM_OPS = 36,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ENV_W   = 9,
    parameter int unsigned CNT_W   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_strobe,
    output logic [OP_W-1:0]  op_sel,
    input  logic [3:0]       ar,
    input  logic [3:0]       dr,
    input  logic [3:0]       sl,
    input  logic [3:0]       rr,
    input  logic [5:0]       tl,
    input  logic [2:0]       block,
    input  logic [9:0]       fnum,
    input  logic             nts,
    input  logic             ksr,
    input  logic             kon,
    input  logic             sus,
    input  logic             am,
    input  logic [1:0]       ksl,
    input  logic             op_reset,
    input  logic [5:0]       am_val,
    output logic [ENV_W-1:0] env,
    output logic [OP_W-1:0]  env_op,
    output logic             env_valid,
    output logic             done,
    output logic             busy,
    output logic             overrun
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [1:0] STG_ATTACK  = 2'd0;
    localparam logic [1:0] STG_DECAY   = 2'd1;
    localparam logic [1:0] STG_SUSTAIN = 2'd2;
    localparam logic [1:0] STG_RELEASE = 2'd3;

    localparam logic [ENV_W-1:0] ENV_MAX   = {ENV_W{1'b1}};
    localparam logic [OP_W-1:0]  LAST_SLOT = OP_W'(NUM_OPS - 1);

    // Per-slot state
    logic [1:0]         stage_mem [NUM_OPS];
    logic [CNT_W-1:0]   cnt_mem   [NUM_OPS];
    logic [ENV_W-1:0]   env_mem   [NUM_OPS];
    logic [NUM_OPS-1:0] kon_prev_mem;

    logic [1:0]      state;
    logic [OP_W-1:0] slot;

    // Key handling and rate counter
    logic [1:0]       cur_stage, key_stage;
    logic [ENV_W-1:0] cur_env, key_env;
    logic [CNT_W-1:0] cur_cnt, cnt_step;
    logic [3:0]       stage_rate, rof_full, rof;
    logic [6:0]       rate_sum;
    logic [5:0]       rate;
    logic [CNT_W+2:0] step, cnt_sum;
    logic [2:0]       ovf;

    // Envelope update
    logic [ENV_W+2:0] atk_prod;
    logic [ENV_W-1:0] atk_dec;
    logic [ENV_W:0]   env_inc;
    logic [ENV_W-1:0] env_inc_sat;
    logic [4:0]       sus_lvl;
    logic [1:0]       next_stage;
    logic [ENV_W-1:0] next_env;
    logic [CNT_W-1:0] next_cnt;

    // Attenuation
    logic [6:0]       ksl_rom;
    logic [8:0]       ksl_pos, ksl_neg, eg_ksl, eg_ksl_sh;
    logic [3:0]       oct_gap;
    logic [9:0]       lvl;
    logic [ENV_W+1:0] att_sum;
    logic [ENV_W-1:0] att;

    logic unused_bits;
    assign unused_bits = ^{fnum[5:0], atk_prod[2:0]};

    assign op_sel = slot;
    assign busy   = (state != ST_IDLE);

    // Key-on edge handling, stage rate selection and rate counter advance
    always_comb begin
        cur_stage = stage_mem[slot];
        cur_env   = env_mem[slot];
        cur_cnt   = cnt_mem[slot];
        key_stage = cur_stage;
        key_env   = cur_env;
        if (!kon) begin
            key_stage = STG_RELEASE;
        end else if (!kon_prev_mem[slot]) begin
            // Retrigger from any stage; rate 15 attack jumps straight to zero
            key_stage = STG_ATTACK;
            if (ar == 4'hf) key_env = '0;
        end

        case (key_stage)
            STG_ATTACK:  stage_rate = ar;
            STG_DECAY:   stage_rate = dr;
            STG_SUSTAIN: stage_rate = sus ? 4'd0 : rr;
            default:     stage_rate = rr;
        endcase

        rof_full = {block, nts ? fnum[8] : fnum[9]};
        rof      = ksr ? rof_full : (rof_full >> 2);
        rate_sum = {3'b000, rof} + {1'b0, stage_rate, 2'b00};
        rate     = (rate_sum > 7'd63) ? 6'd63 : rate_sum[5:0];
        step     = (CNT_W+3)'({1'b1, rate[1:0]}) << rate[5:2];
        cnt_sum  = {3'b000, cur_cnt} + step;
        if (stage_rate != 4'd0) begin
            ovf      = cnt_sum[CNT_W+2:CNT_W];
            cnt_step = cnt_sum[CNT_W-1:0];
        end else begin
            ovf      = 3'd0;
            cnt_step = cur_cnt;
        end
    end

    // ADSR stage transition and envelope step
    always_comb begin
        atk_prod    = (ENV_W+3)'(key_env) * (ENV_W+3)'(ovf);
        atk_dec     = atk_prod[ENV_W+2:3] + ENV_W'(1);
        env_inc     = {1'b0, key_env} + (ENV_W+1)'(ovf);
        env_inc_sat = env_inc[ENV_W] ? ENV_MAX : env_inc[ENV_W-1:0];
        sus_lvl     = (sl == 4'hf) ? 5'd31 : {1'b0, sl};

        next_stage = key_stage;
        next_env   = key_env;
        next_cnt   = cnt_step;
        case (key_stage)
            STG_ATTACK: begin
                if (key_env == '0) begin
                    next_stage = STG_DECAY;
                end else if (ovf != 3'd0) begin
                    next_env = (key_env >= atk_dec) ? (key_env - atk_dec) : '0;
                end
            end
            STG_DECAY: begin
                if (key_env[ENV_W-1:ENV_W-5] >= sus_lvl) next_stage = STG_SUSTAIN;
                else next_env = env_inc_sat;
            end
            default: next_env = env_inc_sat;
        endcase

        if (op_reset) begin
            next_stage = STG_RELEASE;
            next_env   = ENV_MAX;
            next_cnt   = '0;
        end
    end

    // Total attenuation: envelope + total level + key-scale level + tremolo
    always_comb begin
        case (fnum[9:6])
            4'd0:    ksl_rom = 7'd0;
            4'd1:    ksl_rom = 7'd32;
            4'd2:    ksl_rom = 7'd40;
            4'd3:    ksl_rom = 7'd45;
            4'd4:    ksl_rom = 7'd48;
            4'd5:    ksl_rom = 7'd51;
            4'd6:    ksl_rom = 7'd53;
            4'd7:    ksl_rom = 7'd55;
            4'd8:    ksl_rom = 7'd56;
            4'd9:    ksl_rom = 7'd58;
            4'd10:   ksl_rom = 7'd59;
            4'd11:   ksl_rom = 7'd60;
            4'd12:   ksl_rom = 7'd61;
            4'd13:   ksl_rom = 7'd62;
            4'd14:   ksl_rom = 7'd63;
            default: ksl_rom = 7'd64;
        endcase
        ksl_pos = {ksl_rom, 2'b00};
        oct_gap = 4'd8 - {1'b0, block};
        ksl_neg = {oct_gap, 5'b00000};
        eg_ksl  = (ksl_pos > ksl_neg) ? (ksl_pos - ksl_neg) : '0;
        case (ksl)
            2'd0:    eg_ksl_sh = eg_ksl >> 8;
            2'd1:    eg_ksl_sh = eg_ksl >> 1;
            2'd2:    eg_ksl_sh = eg_ksl >> 2;
            default: eg_ksl_sh = eg_ksl;
        endcase
        lvl     = {2'b00, tl, 2'b00} + {1'b0, eg_ksl_sh};
        att_sum = (ENV_W+2)'(next_env) + ((ENV_W+2)'(lvl) << (ENV_W - 9))
                + (am ? ((ENV_W+2)'(am_val) << (ENV_W - 9)) : '0);
        att     = (|att_sum[ENV_W+1:ENV_W]) ? ENV_MAX : att_sum[ENV_W-1:0];
    end

    // Sequencer: INIT clear sweep, IDLE wait, RUN slot walk; sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_INIT;
            slot    <= '0;
            overrun <= 1'b0;
        end else begin
            if (sample_strobe && (state != ST_IDLE)) overrun <= 1'b1;
            case (state)
                ST_INIT: begin
                    if (slot == LAST_SLOT) begin
                        state <= ST_IDLE;
                        slot  <= '0;
                    end else begin
                        slot <= slot + OP_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (sample_strobe) begin
                        state <= ST_RUN;
                        slot  <= '0;
                    end
                end
                ST_RUN: begin
                    if (slot == LAST_SLOT) begin
                        state <= ST_IDLE;
                        slot  <= '0;
                    end else begin
                        slot <= slot + OP_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                    slot  <= '0;
                end
            endcase
        end
    end

    // Slot state write-back: defaults during INIT, updated state during RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                stage_mem[slot]    <= STG_RELEASE;
                env_mem[slot]      <= ENV_MAX;
                cnt_mem[slot]      <= '0;
                kon_prev_mem[slot] <= 1'b0;
            end else if (state == ST_RUN) begin
                stage_mem[slot]    <= next_stage;
                env_mem[slot]      <= next_env;
                cnt_mem[slot]      <= next_cnt;
                kon_prev_mem[slot] <= kon;
            end
        end
    end

    // Registered attenuation output; done coincides with the last slot's valid
    always_ff @(posedge clk) begin
        if (reset) begin
            env       <= '0;
            env_op    <= '0;
            env_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            env_valid <= (state == ST_RUN);
            done      <= (state == ST_RUN) && (slot == LAST_SLOT);
            if (state == ST_RUN) begin
                env    <= att;
                env_op <= slot;
            end
        end
    end

endmodule
